aes_key_expand: RTL and testbench

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

---
 rtl/aes_key_expand_if.sv | 33 +++
 rtl/aes_key_expand.sv | 126 ++++++++++++
 tb/tb_aes_key_expand.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_expand_if.sv
// Round-key bus between the round controller and the AES-128 key expander.
// last_key exists only when AES_KEYEXP_LAST_KEY_EN is defined.
interface aes_key_expand_if;
    logic         kld;
    logic [127:0] key;
    logic         adv;
    logic [31:0]  w0;
    logic [31:0]  w1;
    logic [31:0]  w2;
    logic [31:0]  w3;
    logic [3:0]   rnd;
    logic         kvalid;
    logic         kdone;
`ifdef AES_KEYEXP_LAST_KEY_EN
    logic [127:0] last_key;
`endif

    modport master (
        output kld, key, adv,
        input  w0, w1, w2, w3, rnd, kvalid, kdone
`ifdef AES_KEYEXP_LAST_KEY_EN
        , input last_key
`endif
    );

    modport slave (
        input  kld, key, adv,
        output w0, w1, w2, w3, rnd, kvalid, kdone
`ifdef AES_KEYEXP_LAST_KEY_EN
        , output last_key
`endif
    );
endinterface

// File: rtl/aes_key_expand.sv
// AES-128 iterative key expander: one round key per adv pulse, rounds 0..10.
// Optional feature macro: AES_KEYEXP_LAST_KEY_EN adds the registered last_key output.

// Combinational AES S-box: GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] pw;
        logic [7:0] acc;
        pw  = x;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            pw  = gf_mul(pw, pw);
            acc = gf_mul(acc, pw);
        end
        return acc;
    endfunction

    logic [7:0] w_inv;

    always_comb begin
        w_inv  = gf_inv(i_byte);
        o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_expand (
    input logic              clk,
    input logic              rst,
    aes_key_expand_if.slave  bus
);
    logic [31:0] r_w0, r_w1, r_w2, r_w3;
    logic [3:0]  r_rnd;
    logic        r_kvalid;
    logic        r_kdone;
    logic [7:0]  r_rcon;

    logic [31:0] w_rot, w_sub, w_t;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;
    logic        w_adv_ok;

    // Load wins over advance; a finished or unloaded expansion ignores adv.
    assign w_adv_ok = bus.adv && !bus.kld && r_kvalid && (r_rnd < 4'd10);

    assign w_rot = {r_w3[23:0], r_w3[31:24]};

    aes_sbox u_sbox0 (.i_byte(w_rot[31:24]), .o_byte(w_sub[31:24]));
    aes_sbox u_sbox1 (.i_byte(w_rot[23:16]), .o_byte(w_sub[23:16]));
    aes_sbox u_sbox2 (.i_byte(w_rot[15:8]),  .o_byte(w_sub[15:8]));
    aes_sbox u_sbox3 (.i_byte(w_rot[7:0]),   .o_byte(w_sub[7:0]));

    // r_rcon already holds rcon(rnd+1) because it restarts at 01 on every load.
    assign w_t  = w_sub ^ {r_rcon, 24'h0};
    assign w_n0 = r_w0 ^ w_t;
    assign w_n1 = w_n0 ^ r_w1;
    assign w_n2 = w_n1 ^ r_w2;
    assign w_n3 = w_n2 ^ r_w3;

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w0     <= 32'h0;
            r_w1     <= 32'h0;
            r_w2     <= 32'h0;
            r_w3     <= 32'h0;
            r_rnd    <= 4'd0;
            r_kvalid <= 1'b0;
            r_kdone  <= 1'b0;
            r_rcon   <= 8'h01;
        end else if (bus.kld) begin
            r_w0     <= bus.key[127:96];
            r_w1     <= bus.key[95:64];
            r_w2     <= bus.key[63:32];
            r_w3     <= bus.key[31:0];
            r_rnd    <= 4'd0;
            r_kvalid <= 1'b1;
            r_kdone  <= 1'b0;
            r_rcon   <= 8'h01;
        end else if (w_adv_ok) begin
            r_w0    <= w_n0;
            r_w1    <= w_n1;
            r_w2    <= w_n2;
            r_w3    <= w_n3;
            r_rnd   <= r_rnd + 4'd1;
            r_kdone <= (r_rnd == 4'd9);
            r_rcon  <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
        end
    end

    assign bus.w0     = r_w0;
    assign bus.w1     = r_w1;
    assign bus.w2     = r_w2;
    assign bus.w3     = r_w3;
    assign bus.rnd    = r_rnd;
    assign bus.kvalid = r_kvalid;
    assign bus.kdone  = r_kdone;

`ifdef AES_KEYEXP_LAST_KEY_EN
    logic [127:0] r_last_key;

    // Survives kld so the previous final key stays readable until a new expansion completes.
    always_ff @(posedge clk) begin
        if (rst)
            r_last_key <= 128'h0;
        else if (w_adv_ok && (r_rnd == 4'd9))
            r_last_key <= {w_n0, w_n1, w_n2, w_n3};
    end

    assign bus.last_key = r_last_key;
`endif
endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 key-expansion vectors.
// Exercises last_key as well when AES_KEYEXP_LAST_KEY_EN is defined.
module tb_aes_key_expand;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_A_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY_A_R2 = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] KEY_A_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

    aes_key_expand_if bus ();

    aes_key_expand dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] cur_key();
        return {bus.w0, bus.w1, bus.w2, bus.w3};
    endfunction

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [127:0] k);
        bus.kld = 1'b1;
        bus.key = k;
        tick(1);
        bus.kld = 1'b0;
    endtask

    task automatic advance(input int n);
        bus.adv = 1'b1;
        tick(n);
        bus.adv = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        n_cmp++;
        if (cur_key() !== 128'h0) begin
            n_err++;
            $display("FAIL reset_w: got %h want %h", cur_key(), 128'h0);
        end
        n_cmp++;
        if ({bus.rnd, bus.kvalid, bus.kdone} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got rnd=%0d kvalid=%b kdone=%b want 0/0/0", bus.rnd, bus.kvalid, bus.kdone);
        end
    endtask

    task automatic test_load();
        load(KEY_A);
        n_cmp++;
        if (cur_key() !== KEY_A) begin
            n_err++;
            $display("FAIL load_w: got %h want %h", cur_key(), KEY_A);
        end
        n_cmp++;
        if ({bus.rnd, bus.kvalid, bus.kdone} !== {4'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL load_flags: got rnd=%0d kvalid=%b kdone=%b want 0/1/0", bus.rnd, bus.kvalid, bus.kdone);
        end
    endtask

    task automatic test_rounds();
        advance(1);
        n_cmp++;
        if (cur_key() !== KEY_A_R1 || bus.rnd !== 4'd1) begin
            n_err++;
            $display("FAIL round1: got %h rnd=%0d want %h rnd=1", cur_key(), bus.rnd, KEY_A_R1);
        end
        advance(1);
        n_cmp++;
        if (cur_key() !== KEY_A_R2 || bus.rnd !== 4'd2) begin
            n_err++;
            $display("FAIL round2: got %h rnd=%0d want %h rnd=2", cur_key(), bus.rnd, KEY_A_R2);
        end
    endtask

    task automatic test_hold();
        tick(3);
        n_cmp++;
        if (cur_key() !== KEY_A_R2 || bus.rnd !== 4'd2 || bus.kdone !== 1'b0) begin
            n_err++;
            $display("FAIL hold: got %h rnd=%0d kdone=%b want %h rnd=2 kdone=0", cur_key(), bus.rnd, bus.kdone, KEY_A_R2);
        end
    endtask

    task automatic test_full_expansion();
        load(KEY_A);
        advance(9);
        n_cmp++;
        if (bus.rnd !== 4'd9 || bus.kdone !== 1'b0) begin
            n_err++;
            $display("FAIL pre_done: got rnd=%0d kdone=%b want rnd=9 kdone=0", bus.rnd, bus.kdone);
        end
        advance(1);
        n_cmp++;
        if (cur_key() !== KEY_A_RA || bus.rnd !== 4'd10 || bus.kdone !== 1'b1) begin
            n_err++;
            $display("FAIL round10: got %h rnd=%0d kdone=%b want %h rnd=10 kdone=1", cur_key(), bus.rnd, bus.kdone, KEY_A_RA);
        end
        advance(1);
        n_cmp++;
        if (cur_key() !== KEY_A_RA || bus.rnd !== 4'd10 || bus.kdone !== 1'b1 || bus.kvalid !== 1'b1) begin
            n_err++;
            $display("FAIL adv_after_done: got %h rnd=%0d kdone=%b want %h rnd=10 kdone=1", cur_key(), bus.rnd, bus.kdone, KEY_A_RA);
        end
`ifdef AES_KEYEXP_LAST_KEY_EN
        n_cmp++;
        if (bus.last_key !== KEY_A_RA) begin
            n_err++;
            $display("FAIL last_key: got %h want %h", bus.last_key, KEY_A_RA);
        end
`endif
    endtask

    task automatic test_restart();
        load(KEY_A);
        advance(3);
        n_cmp++;
        if (bus.rnd !== 4'd3) begin
            n_err++;
            $display("FAIL restart_pre: got rnd=%0d want 3", bus.rnd);
        end
        load(KEY_B);
        n_cmp++;
        if (cur_key() !== KEY_B || bus.rnd !== 4'd0 || bus.kdone !== 1'b0) begin
            n_err++;
            $display("FAIL restart_load: got %h rnd=%0d want %h rnd=0", cur_key(), bus.rnd, KEY_B);
        end
        advance(1);
        n_cmp++;
        if (cur_key() !== KEY_B_R1 || bus.rnd !== 4'd1) begin
            n_err++;
            $display("FAIL restart_round1: got %h rnd=%0d want %h rnd=1", cur_key(), bus.rnd, KEY_B_R1);
        end
`ifdef AES_KEYEXP_LAST_KEY_EN
        n_cmp++;
        if (bus.last_key !== KEY_A_RA) begin
            n_err++;
            $display("FAIL last_key_kept: got %h want %h", bus.last_key, KEY_A_RA);
        end
`endif
    endtask

    task automatic test_kld_adv();
        bus.adv = 1'b1;
        load(KEY_A);
        bus.adv = 1'b0;
        n_cmp++;
        if (cur_key() !== KEY_A || bus.rnd !== 4'd0 || bus.kvalid !== 1'b1) begin
            n_err++;
            $display("FAIL kld_adv: got %h rnd=%0d kvalid=%b want %h rnd=0 kvalid=1", cur_key(), bus.rnd, bus.kvalid, KEY_A);
        end
    endtask

    task automatic test_reset_mid();
        load(KEY_B);
        advance(5);
        n_cmp++;
        if (bus.rnd !== 4'd5) begin
            n_err++;
            $display("FAIL mid_pre: got rnd=%0d want 5", bus.rnd);
        end
        rst     = 1'b1;
        bus.adv = 1'b1;
        tick(1);
        rst = 1'b0;
        n_cmp++;
        if (cur_key() !== 128'h0 || {bus.rnd, bus.kvalid, bus.kdone} !== 6'b0) begin
            n_err++;
            $display("FAIL mid_reset: got %h rnd=%0d kvalid=%b kdone=%b want all zero", cur_key(), bus.rnd, bus.kvalid, bus.kdone);
        end
`ifdef AES_KEYEXP_LAST_KEY_EN
        n_cmp++;
        if (bus.last_key !== 128'h0) begin
            n_err++;
            $display("FAIL mid_reset_last_key: got %h want 0", bus.last_key);
        end
`endif
        tick(3);
        bus.adv = 1'b0;
        n_cmp++;
        if (cur_key() !== 128'h0 || {bus.rnd, bus.kvalid, bus.kdone} !== 6'b0) begin
            n_err++;
            $display("FAIL adv_no_key: got %h rnd=%0d kvalid=%b want all zero", cur_key(), bus.rnd, bus.kvalid);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        bus.kld = 1'b0;
        bus.adv = 1'b0;
        bus.key = 128'h0;
        test_reset();
        test_load();
        test_rounds();
        test_hold();
        test_full_expansion();
        test_restart();
        test_kld_adv();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
